// File: rtl/reg_bank_sb_s.sv
// Register file with N combinational read ports, gated write bypass, pending-write scoreboard and clear sweep.
// Optional per-register even parity with rd_perr_o output when REG_BANK_PARITY_EN is defined.
module reg_bank_sb_s #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned BYPASS = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_en_i,
  input  logic [ADDR_W-1:0]        wr_dir_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  input  logic                     iss_en_i,
  input  logic [ADDR_W-1:0]        iss_dir_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_dir_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  output logic [NUM_RD-1:0]        rd_busy_o,
`ifdef REG_BANK_PARITY_EN
  output logic [NUM_RD-1:0]        rd_perr_o,
`endif
  input  logic                     clr_req_i,
  output logic                     clr_busy_o,
  output logic                     clr_done_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {ST_IDLE, ST_CLEAR} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   prf_q [DEPTH];
  logic [DEPTH-1:0]    pend_q;
`ifdef REG_BANK_PARITY_EN
  logic [DEPTH-1:0]    par_q;
`endif

  logic idle_c, wr_ok_c, iss_ok_c;
  assign idle_c   = (state_q == ST_IDLE);
  assign wr_ok_c  = idle_c && wr_en_i && (wr_dir_i != '0);
  assign iss_ok_c = idle_c && iss_en_i && (iss_dir_i != '0);

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_req_i) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        cnt_d = ADDR_W'(cnt_q + 1'b1);
        if (cnt_q == LAST) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs; reset suppresses a done pulse in its own cycle
  always_comb begin
    clr_busy_o = 1'b0;
    clr_done_o = 1'b0;
    if (state_q == ST_CLEAR) begin
      clr_busy_o = 1'b1;
      clr_done_o = (cnt_q == LAST) && !rst_i;
    end
  end

  // Array, pending bits; later assignments win (issue over write, clear over both)
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) prf_q[i] <= '0;
      pend_q <= '0;
`ifdef REG_BANK_PARITY_EN
      par_q  <= '0;
`endif
    end else if (idle_c) begin
      if (wr_ok_c) begin
        prf_q[wr_dir_i]  <= wr_data_i;
        pend_q[wr_dir_i] <= 1'b0;
`ifdef REG_BANK_PARITY_EN
        par_q[wr_dir_i]  <= ^wr_data_i;
`endif
      end
      if (iss_ok_c) pend_q[iss_dir_i] <= 1'b1;
      if (clr_req_i) pend_q <= '0;
    end else begin
      prf_q[cnt_q] <= '0;
`ifdef REG_BANK_PARITY_EN
      par_q[cnt_q] <= 1'b0;
`endif
    end
  end

  logic [ADDR_W-1:0] ra_c;
  logic              byp_c;

  // Read ports: r0 forced to zero, bypass only on a qualified write
  always_comb begin
    rd_data_o = '0;
    rd_busy_o = '0;
`ifdef REG_BANK_PARITY_EN
    rd_perr_o = '0;
`endif
    ra_c  = '0;
    byp_c = 1'b0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      ra_c  = rd_dir_i[k*ADDR_W +: ADDR_W];
      byp_c = (BYPASS != 0) && wr_ok_c && (wr_dir_i == ra_c);
      if (ra_c == '0) begin
        rd_data_o[k*DATA_W +: DATA_W] = '0;
      end else if (byp_c) begin
        rd_data_o[k*DATA_W +: DATA_W] = wr_data_i;
      end else begin
        rd_data_o[k*DATA_W +: DATA_W] = prf_q[ra_c];
        rd_busy_o[k] = idle_c && pend_q[ra_c];
`ifdef REG_BANK_PARITY_EN
        rd_perr_o[k] = (^prf_q[ra_c]) != par_q[ra_c];
`endif
      end
    end
  end

endmodule
